apb_regfile_slave: RTL
======================

Name: apb_regfile_slave

Overview:
- Parametrised APB3 slave that fronts a bank of NUM_REGS read/write registers.
- Supports configurable wait states, per-byte write strobes and PSLVERR on bad addresses.
- Exports the register contents and per-register write pulses to the core logic.
- Sits behind the APB bridge and is the general-purpose control/status register block for peripherals.

Parameters:
- ADDR_WIDTH, 8, width of i_paddr (byte address).
- DATA_WIDTH, 32, bus and register width; must be 8, 16 or 32.
- NUM_REGS, 16, number of registers; 1 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, number of access-phase cycles with o_pready low before completion; 0 to 15.
- RESET_VALUE, 0, reset value loaded into every register (DATA_WIDTH bits).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_paddr  in  ADDR_WIDTH  byte address.
- i_psel  in  1  slave select.
- i_penable  in  1  access phase indicator.
- i_pwrite  in  1  1 = write, 0 = read.
- i_pwdata  in  DATA_WIDTH  write data.
- i_pstrb  in  DATA_WIDTH/8  byte write strobes.
- o_pready  out  1  transfer completion.
- o_pslverr  out  1  transfer error; valid only with o_pready.
- o_prdata  out  DATA_WIDTH  read data; valid only with o_pready on reads.
- o_regs  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg k is at bits [k*DW +: DW].
- o_wr_pulse  out  NUM_REGS  one-cycle pulse, bit k set the cycle after reg k is written.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - All registers set to RESET_VALUE; FSM goes to IDLE; wait counter cleared.
  - o_pready=0, o_pslverr=0, o_prdata=0, o_wr_pulse=0.
  - Reset mid-transfer aborts it: no write, no o_pready.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); index = i_paddr >> LSB.
  - Error if index >= NUM_REGS, or if i_paddr[LSB-1:0] != 0 (misaligned; DATA_WIDTH=8 has no alignment check).
- FSM states IDLE, ACCESS:
  - IDLE:
    - i_psel=1 and i_penable=0 (setup phase): go to ACCESS, load counter with WAIT_STATES.
    - i_penable=1 without a prior setup phase: ignored, stay IDLE.
  - ACCESS with i_psel=1 and i_penable=1:
    - If counter != 0: decrement, o_pready=0.
    - If counter == 0: o_pready=1 combinationally this cycle, transfer completes, next state IDLE.
  - ACCESS with i_psel=0: protocol abort. Return to IDLE; no write, no o_pready.
  - ACCESS with i_psel=1 and i_penable=0: treated as a fresh setup. Reload counter, stay ACCESS.
- Back-to-back transfers: the completion cycle returns to IDLE, so the next setup phase is accepted on the following cycle (APB minimum of 2 cycles per transfer plus WAIT_STATES).
- Outputs are combinational from FSM state, counter and current bus inputs:
  - o_pready is 1 only in the completion cycle.
  - o_pslverr = o_pready & decode error.
  - o_prdata = selected register when o_pready & !i_pwrite & !error; otherwise 0.
- Write, at the completion edge, if no error:
  - Register byte b takes i_pwdata byte b where i_pstrb[b]=1; other bytes are unchanged.
  - o_wr_pulse[index] is 1 in the next cycle only, even when i_pstrb=0.
- Erroring writes change no register and raise no pulse.
- Reads have no side effects. Read during write to the same register returns the old value.
- i_pstrb is ignored on reads. Address, data and control are sampled in the completion cycle; the master holds them stable per APB.
- o_regs reflects the registers directly and updates the cycle after the write edge.

Test Plan:
- Reset release, WAIT_STATES=0:
  - Read addr 0x04 -> o_pready=1 in the first access cycle, o_prdata=0x00000000, o_pslverr=0.
- Write 0xDEADBEEF to addr 0x08 with pstrb=4'b1111, then read 0x08:
  - Read returns 0xDEADBEEF.
  - o_wr_pulse=16'h0004 for exactly one cycle after the write completion.
  - o_regs[95:64]=0xDEADBEEF.
- Partial write 0x11223344 to 0x08 with pstrb=4'b0101 over 0xDEADBEEF -> reg2 reads back 0xDE22BE44.
- WAIT_STATES=3, read 0x00:
  - o_pready low for 3 access cycles, high on the 4th.
  - Total transfer is 5 cycles including setup.
- Error cases, each giving o_pready=1 and o_pslverr=1 with no register change and no o_wr_pulse:
  - Write to 0x40 (index 16 with NUM_REGS=16).
  - Write to 0x06 (misaligned).
  - Read 0x40 -> o_prdata=0.
- Aborts:
  - i_psel deasserted mid-ACCESS with WAIT_STATES=2 -> no write, FSM back to IDLE, next transfer completes normally.
  - i_reset asserted during ACCESS -> all registers return to RESET_VALUE and o_pready=0.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB3 slave fronting NUM_REGS read/write registers with byte strobes,
// programmable wait states and PSLVERR on out-of-range or misaligned addresses.
module apb_regfile_slave #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
    output logic                           o_pready,
    output logic                           o_pslverr,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);
    localparam int                    NB         = DATA_WIDTH / 8;
    localparam int                    LSB        = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDR_WIDTH:0]   NREGS      = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                              state_q, state_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]               idx;
    logic [NUM_REGS-1:0]                 sel;
    logic [DATA_WIDTH-1:0]               rd_mux;
    logic                                dec_err;
    logic                                done;

    assign idx     = i_paddr >> LSB;
    assign dec_err = ({1'b0, idx} >= NREGS) || ((i_paddr & ALIGN_MASK) != '0);

    // One-hot register select; all zero on a decode error so reads return 0.
    always_comb begin
        sel    = '0;
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            sel[k] = !dec_err && (idx == ADDR_WIDTH'(k));
            if (sel[k]) rd_mux = regs_q[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (!i_psel) begin
                    state_d = IDLE;
                end else if (!i_penable) begin
                    cnt_d = WAIT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (i_pwrite) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (sel[k]) begin
                                wr_pulse_d[k] = 1'b1;
                                for (int b = 0; b < NB; b++)
                                    if (i_pstrb[b]) regs_d[k][b*8 +: 8] = i_pwdata[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // A reset landing on the completion cycle kills the handshake as well as the write.
    assign o_pready   = done && !i_reset;
    assign o_pslverr  = o_pready && dec_err;
    assign o_prdata   = (o_pready && !i_pwrite && !dec_err) ? rd_mux : '0;
    assign o_regs     = regs_q;
    assign o_wr_pulse = wr_pulse_q;
endmodule
